i2c_slave_ctrl: RTL and testbench

Synthesizable I2C target that answers the I2C master on the same i2c_sda/i2c_scl bus. It replaces the behavioural slave model in the APB-to-I2C subsystem.
- Master write: received bytes are pushed toward an RX FIFO.
- Master read: bytes are pulled from a TX FIFO and shifted out.
- Single clock domain; SCL/SDA are oversampled, so no clock stretching is performed.

---
 rtl/i2c_slave_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// I2C target: receives master writes into an RX FIFO and answers master reads from a TX FIFO.
// SCL/SDA are oversampled on clk; SDA is open-drain (0 or z), SCL is never driven.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DATAWIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 i2c_reset_n,
  input  logic                 i2c_scl,
  inout  wire                  i2c_sda,
  output logic [DATAWIDTH-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_full,
  input  logic [DATAWIDTH-1:0] tx_data,
  output logic                 tx_rd_en,
  input  logic                 tx_empty,
  output logic                 tx_underrun,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t               state;
  logic                 scl_s1, scl_s2, scl_prev;
  logic                 sda_s1, sda_s2, sda_prev;
  logic [3:0]           bit_cnt;
  logic [DATAWIDTH-1:0] shift;
  logic                 rw;
  logic                 sda_oe;
  logic                 tx_load;
  logic                 wr_nack;

  logic scl_rise, scl_fall, start_det, stop_det, fetch_now;

  // Bus handshake: the target only ever pulls SDA low; a 1 is a released line.
  assign i2c_sda   = sda_oe ? 1'b0 : 1'bz;
  assign state_dbg = state;

  assign scl_rise  = scl_s2 & ~scl_prev;
  assign scl_fall  = ~scl_s2 & scl_prev;
  assign start_det = scl_s2 & scl_prev & sda_prev & ~sda_s2;
  assign stop_det  = scl_s2 & scl_prev & ~sda_prev & sda_s2;

  // A byte fetch happens on the ACK rise after the address (read) or after a master ACK.
  assign fetch_now = scl_rise && !start_det && !stop_det &&
                     ((state == ADDR_ACK && rw) || (state == RD_ACK && !sda_s2));

  always_ff @(posedge clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_prev <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_s1   <= i2c_scl;
      scl_s2   <= scl_s1;
      scl_prev <= scl_s2;
      sda_s1   <= i2c_sda;
      sda_s2   <= sda_s1;
      sda_prev <= sda_s2;
    end
  end

  always_ff @(posedge clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shift       <= '0;
      rw          <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_rd_en    <= 1'b0;
      tx_underrun <= 1'b0;
      tx_load     <= 1'b0;
      wr_nack     <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_rd_en    <= 1'b0;
      tx_underrun <= 1'b0;
      tx_load     <= tx_rd_en;
      if (tx_load) shift <= tx_data;
      if (fetch_now) begin
        if (!tx_empty) begin
          tx_rd_en <= 1'b1;
        end else begin
          tx_underrun <= 1'b1;
          shift       <= '1;
        end
      end

      if (stop_det) begin
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= 4'd0;
        state   <= IDLE;
      end else if (start_det) begin
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= 4'd0;
        state   <= ADDR;
      end else begin
        case (state)
          IDLE: ;
          ADDR, WR_DATA: begin
            if (scl_rise && bit_cnt < 4'(DATAWIDTH)) begin
              shift   <= {shift[DATAWIDTH-2:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'(DATAWIDTH)) begin
              bit_cnt <= 4'd0;
              if (state == ADDR) begin
                if (shift[DATAWIDTH-1:1] == SLAVE_ADDR) begin
                  sda_oe <= 1'b1;
                  busy   <= 1'b1;
                  rw     <= shift[0];
                  state  <= ADDR_ACK;
                end else begin
                  state <= WAIT_STOP;
                end
              end else begin
                state <= WR_ACK;
                if (!rx_full) begin
                  rx_data  <= shift;
                  rx_valid <= 1'b1;
                  sda_oe   <= 1'b1;
                  wr_nack  <= 1'b0;
                end else begin
                  wr_nack <= 1'b1;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                sda_oe  <= ~shift[DATAWIDTH-1];
                shift   <= {shift[DATAWIDTH-2:0], 1'b1};
                bit_cnt <= 4'd1;
                state   <= RD_DATA;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= WR_DATA;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= wr_nack ? WAIT_STOP : WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'(DATAWIDTH)) begin
                sda_oe <= 1'b0;
                state  <= RD_ACK;
              end else begin
                sda_oe  <= ~shift[DATAWIDTH-1];
                shift   <= {shift[DATAWIDTH-2:0], 1'b1};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          RD_ACK: begin
            // A master NACK leaves on the rise; reaching the fall here means it ACKed.
            if (scl_rise && sda_s2) begin
              state <= WAIT_STOP;
            end else if (scl_fall) begin
              sda_oe  <= ~shift[DATAWIDTH-1];
              shift   <= {shift[DATAWIDTH-2:0], 1'b1};
              bit_cnt <= 4'd1;
              state   <= RD_DATA;
            end
          end
          WAIT_STOP: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: a bit-level I2C master, a TX FIFO model and an RX scoreboard.
module tb_i2c_slave_ctrl;
  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       m_low;
  wire        i2c_sda;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_full;
  logic [7:0] tx_data = 8'h00;
  logic       tx_rd_en;
  logic       tx_empty = 1'b1;
  logic       tx_underrun;
  logic       busy;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;
  int n_rx = 0, n_pop = 0, n_unf = 0, dut_low = 0;
  int base_rx, base_pop, base_unf;
  logic [7:0] exp_q[$];
  logic [7:0] tx_fifo[$];
  logic [7:0] rd_byte;
  logic       ack;
  logic       bit_v;

  always #5 clk = ~clk;

  assign i2c_sda = m_low ? 1'b0 : 1'bz;
  pullup (i2c_sda);

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h50), .DATAWIDTH(8)) dut (
    .clk(clk), .i2c_reset_n(rst_n), .i2c_scl(scl), .i2c_sda(i2c_sda),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
    .tx_data(tx_data), .tx_rd_en(tx_rd_en), .tx_empty(tx_empty),
    .tx_underrun(tx_underrun), .busy(busy), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // TX FIFO model: a pop seen on a clk edge presents the head on the next cycle.
  always @(posedge clk) begin
    if (tx_rd_en && tx_fifo.size() > 0) tx_data <= tx_fifo.pop_front();
    tx_empty <= (tx_fifo.size() == 0);
  end

  // Compare process: scoreboard for rx bytes, pop legality, pulse counters.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        n_rx++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected: got %0h expected none", rx_data);
        end else begin
          check("rx_data", rx_data, exp_q.pop_front());
        end
      end
      if (tx_rd_en) begin
        n_pop++;
        check("pop_while_empty", tx_empty, 1'b0);
      end
      if (tx_underrun) n_unf++;
      if (i2c_sda === 1'b0 && !m_low) dut_low++;
    end
  end

  task automatic q_wait();
    repeat (Q) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    m_low = !b;
    q_wait();
    scl = 1'b1;
    q_wait();
    q_wait();
    scl = 1'b0;
    q_wait();
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0;
    q_wait();
    scl = 1'b1;
    q_wait();
    b = i2c_sda;
    q_wait();
    scl = 1'b0;
    q_wait();
  endtask

  task automatic i2c_start();
    if (!scl) begin
      m_low = 1'b0;
      q_wait();
      scl = 1'b1;
    end
    q_wait();
    m_low = 1'b1;
    q_wait();
    scl = 1'b0;
    q_wait();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    q_wait();
    scl = 1'b1;
    q_wait();
    m_low = 1'b0;
    q_wait();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(s);
    acked = !s;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic master_ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(s);
      b[i] = s;
    end
    send_bit(!master_ack);
  endtask

  initial begin
    rst_n = 1'b0; scl = 1'b1; m_low = 1'b0; rx_full = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    q_wait();
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_tx_rd_en", tx_rd_en, 1'b0);
    check("reset_tx_underrun", tx_underrun, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_sda", i2c_sda, 1'b1);

    // Plain write of two bytes
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    i2c_start();
    write_byte(8'hA0, ack); check("wr_addr_ack", ack, 1'b1);
    check("wr_busy", busy, 1'b1);
    write_byte(8'h3C, ack); check("wr_d0_ack", ack, 1'b1);
    write_byte(8'hC3, ack); check("wr_d1_ack", ack, 1'b1);
    i2c_stop();
    q_wait();
    check("wr_busy_after_stop", busy, 1'b0);
    check("wr_rx_count", n_rx, 2);

    // Foreign address: target stays off the bus
    base_rx = n_rx;
    dut_low = 0;
    i2c_start();
    write_byte(8'hA2, ack); check("nm_addr_nack", ack, 1'b0);
    check("nm_busy", busy, 1'b0);
    write_byte(8'h11, ack); check("nm_data_nack", ack, 1'b0);
    i2c_stop();
    check("nm_sda_never_low", dut_low, 0);
    check("nm_rx_count", n_rx, base_rx);
    i2c_start();
    write_byte(8'hA0, ack); check("nm_next_addr_ack", ack, 1'b1);
    i2c_stop();

    // Read two bytes, master NACKs the last
    tx_fifo.push_back(8'h5A);
    tx_fifo.push_back(8'h96);
    q_wait();
    base_pop = n_pop; base_unf = n_unf;
    i2c_start();
    write_byte(8'hA1, ack); check("rd_addr_ack", ack, 1'b1);
    read_byte(rd_byte, 1'b1); check("rd_byte0", rd_byte, 8'h5A);
    read_byte(rd_byte, 1'b0); check("rd_byte1", rd_byte, 8'h96);
    i2c_stop();
    q_wait();
    check("rd_pop_count", n_pop - base_pop, 2);
    check("rd_underrun_count", n_unf - base_unf, 0);

    // Read from an empty TX FIFO
    base_pop = n_pop; base_unf = n_unf;
    i2c_start();
    write_byte(8'hA1, ack); check("un_addr_ack", ack, 1'b1);
    read_byte(rd_byte, 1'b0); check("un_byte", rd_byte, 8'hFF);
    i2c_stop();
    check("un_underrun_count", n_unf - base_unf, 1);
    check("un_pop_count", n_pop - base_pop, 0);

    // RX FIFO full: data NACKed, later bytes ignored until STOP
    base_rx = n_rx;
    i2c_start();
    write_byte(8'hA0, ack); check("full_addr_ack", ack, 1'b1);
    rx_full = 1'b1;
    write_byte(8'h01, ack); check("full_data_nack", ack, 1'b0);
    rx_full = 1'b0;
    write_byte(8'h02, ack); check("full_wait_stop_nack", ack, 1'b0);
    check("full_busy_until_stop", busy, 1'b1);
    i2c_stop();
    q_wait();
    check("full_busy_after_stop", busy, 1'b0);
    check("full_rx_count", n_rx, base_rx);

    // Write then repeated START into a read
    base_rx = n_rx; base_pop = n_pop;
    exp_q.push_back(8'h77);
    tx_fifo.push_back(8'h42);
    i2c_start();
    write_byte(8'hA0, ack); check("rs_addr_w_ack", ack, 1'b1);
    write_byte(8'h77, ack); check("rs_data_ack", ack, 1'b1);
    i2c_start();
    write_byte(8'hA1, ack); check("rs_addr_r_ack", ack, 1'b1);
    read_byte(rd_byte, 1'b0); check("rs_read_byte", rd_byte, 8'h42);
    i2c_stop();
    check("rs_rx_count", n_rx - base_rx, 1);
    check("rs_pop_count", n_pop - base_pop, 1);

    // Async reset while the target drives a 0 bit mid-byte
    tx_fifo.push_back(8'h00);
    q_wait();
    i2c_start();
    write_byte(8'hA1, ack); check("rst_addr_ack", ack, 1'b1);
    for (int i = 0; i < 3; i++) recv_bit(bit_v);
    check("rst_dut_driving", i2c_sda, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_sda_released", i2c_sda, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_tx_rd_en", tx_rd_en, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_underrun", tx_underrun, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    q_wait();
    i2c_stop();
    base_rx = n_rx;
    exp_q.push_back(8'h24);
    i2c_start();
    write_byte(8'hA0, ack); check("rec_addr_ack", ack, 1'b1);
    write_byte(8'h24, ack); check("rec_data_ack", ack, 1'b1);
    i2c_stop();
    check("rec_rx_count", n_rx - base_rx, 1);
    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
